// File: rtl/pipeline_input_queue.sv
// Dual-channel show-ahead staging queue feeding the dual-pipeline wrapper; optional zero-latency bypass via PIPELINE_INPUT_QUEUE_BYPASS_EN.
// Latency 1 cycle push-to-valid (0 with bypass); stall_i holds the head, push_ready_i drops only when full or flushing.

module pipeline_input_queue_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [W-1:0]     rd_dat,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_rdy = count < CNT_W'(DEPTH);
  assign rd_vld = count != '0;
  assign rd_dat = mem[rd_ptr];
  assign wr_en  = wr_vld && wr_rdy && !flush;
  assign rd_en  = rd_vld && rd_rdy && !flush;

  // Storage is deliberately unreset; the head is only meaningful while rd_vld.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module pipeline_input_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_1,
  input  logic [DATA_W-1:0] push_data_1,
  output logic              push_ready_1,
  input  logic              push_2,
  input  logic [DATA_W-1:0] push_data_2,
  output logic              push_ready_2,
  output logic [DATA_W-1:0] pipeline1_inputs,
  output logic [DATA_W-1:0] pipeline2_inputs,
  output logic [1:0]        in_valid,
  input  logic              stall_1,
  input  logic              stall_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic [CNT_W-1:0]  count_1,
  output logic [CNT_W-1:0]  count_2,
  output logic [1:0]        overflow
);
  logic [1:0]        push_v;
  logic [1:0]        stall_v;
  logic [1:0]        flush_v;
  logic [1:0]        ready_v;
  logic [1:0]        not_full;
  logic [1:0]        fifo_vld;
  logic [1:0]        fifo_wr;
  logic [1:0]        fifo_rd;
  logic [1:0]        byp;
  logic [DATA_W-1:0] push_d [2];
  logic [DATA_W-1:0] head_d [2];
  logic [DATA_W-1:0] out_d  [2];
  logic [CNT_W-1:0]  cnt    [2];

  assign push_v    = {push_2, push_1};
  assign stall_v   = {stall_2, stall_1};
  assign flush_v   = {flush_2, flush_1};
  assign push_d[0] = push_data_1;
  assign push_d[1] = push_data_2;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    pipeline_input_queue_fifo #(
      .W     (DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (reset),
      .flush  (flush_v[i]),
      .wr_vld (fifo_wr[i]),
      .wr_dat (push_d[i]),
      .wr_rdy (not_full[i]),
      .rd_vld (fifo_vld[i]),
      .rd_rdy (!stall_v[i]),
      .rd_dat (head_d[i]),
      .count  (cnt[i])
    );

    // Ready is independent of same-cycle pop so stall never reaches ready combinationally.
    assign ready_v[i] = not_full[i] && !flush_v[i];
    assign fifo_rd[i] = fifo_vld[i] && !stall_v[i];

`ifdef PIPELINE_INPUT_QUEUE_BYPASS_EN
    assign byp[i]      = push_v[i] && !fifo_vld[i] && !flush_v[i];
    assign fifo_wr[i]  = push_v[i] && ready_v[i] && !(byp[i] && !stall_v[i]);
    assign in_valid[i] = (fifo_vld[i] || byp[i]) && !flush_v[i];
    assign out_d[i]    = fifo_vld[i] ? head_d[i] : push_d[i];
`else
    assign byp[i]      = 1'b0;
    assign fifo_wr[i]  = push_v[i] && ready_v[i] && !byp[i];
    assign in_valid[i] = fifo_vld[i] && !flush_v[i];
    assign out_d[i]    = head_d[i];
`endif
  end

  assign push_ready_1     = ready_v[0];
  assign push_ready_2     = ready_v[1];
  assign pipeline1_inputs = out_d[0];
  assign pipeline2_inputs = out_d[1];
  assign count_1          = cnt[0];
  assign count_2          = cnt[1];

  // A refused push counts as overflow only when the refusal is due to a full channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 2'b00;
    else        overflow <= overflow | (push_v & ~ready_v & ~flush_v);
  end
endmodule

// File: tb/tb_pipeline_input_queue.sv
// Randomized and directed checks of pipeline_input_queue against a queue-based reference model.
module tb_pipeline_input_queue;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_1, push_2, stall_1, stall_2, flush_1, flush_2;
  logic [DATA_W-1:0] push_data_1, push_data_2;
  logic              push_ready_1, push_ready_2;
  logic [DATA_W-1:0] pipeline1_inputs, pipeline2_inputs;
  logic [1:0]        in_valid, overflow;
  logic [CNT_W-1:0]  count_1, count_2;

  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] q2[$];
  logic [1:0]        ov_m;
  int                tests  = 0;
  int                failed = 0;

  always #5 clk = ~clk;

  pipeline_input_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .push_1(push_1), .push_data_1(push_data_1), .push_ready_1(push_ready_1),
    .push_2(push_2), .push_data_2(push_data_2), .push_ready_2(push_ready_2),
    .pipeline1_inputs(pipeline1_inputs), .pipeline2_inputs(pipeline2_inputs),
    .in_valid(in_valid), .stall_1(stall_1), .stall_2(stall_2),
    .flush_1(flush_1), .flush_2(flush_2),
    .count_1(count_1), .count_2(count_2), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    push_1 = 0; push_2 = 0; stall_1 = 0; stall_2 = 0; flush_1 = 0; flush_2 = 0;
    push_data_1 = '0; push_data_2 = '0;
  endtask

  // Checks outputs mid-cycle, then advances one clock and applies the same inputs to the model.
  task automatic step();
    int n1, n2;
    bit by1, by2, v1, v2, r1, r2;
    #1;
    n1 = q1.size(); n2 = q2.size();
`ifdef PIPELINE_INPUT_QUEUE_BYPASS_EN
    by1 = push_1 && n1 == 0 && !flush_1;
    by2 = push_2 && n2 == 0 && !flush_2;
`else
    by1 = 0; by2 = 0;
`endif
    v1 = (n1 != 0 || by1) && !flush_1;
    v2 = (n2 != 0 || by2) && !flush_2;
    r1 = n1 < DEPTH && !flush_1;
    r2 = n2 < DEPTH && !flush_2;
    chk("in_valid", in_valid, {v2, v1});
    chk("count_1", count_1, n1);
    chk("count_2", count_2, n2);
    chk("push_ready_1", push_ready_1, r1);
    chk("push_ready_2", push_ready_2, r2);
    chk("overflow", overflow, ov_m);
    if (v1) chk("head_1", pipeline1_inputs, (n1 != 0) ? q1[0] : push_data_1);
    if (v2) chk("head_2", pipeline2_inputs, (n2 != 0) ? q2[0] : push_data_2);
    @(posedge clk);
    ov_m = ov_m | {push_2 && !r2 && !flush_2, push_1 && !r1 && !flush_1};
    if (flush_1) q1.delete();
    else if (!(by1 && !stall_1)) begin
      if (v1 && !stall_1) void'(q1.pop_front());
      if (push_1 && r1) q1.push_back(push_data_1);
    end
    if (flush_2) q2.delete();
    else if (!(by2 && !stall_2)) begin
      if (v2 && !stall_2) void'(q2.pop_front());
      if (push_2 && r2) q2.push_back(push_data_2);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    ov_m  = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_in_valid", in_valid, 2'b00);
    chk("rst_count_1", count_1, 0);
    chk("rst_count_2", count_2, 0);
    chk("rst_overflow", overflow, 2'b00);
    chk("rst_ready", {push_ready_2, push_ready_1}, 2'b11);
    @(negedge clk);
    reset = 1'b1;

    // Channel 1 streaming A0..A3 without stall.
    for (int i = 0; i < 4; i++) begin
      push_1 = 1; push_data_1 = 32'hA0 + i;
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("ch1_drained", count_1, 0);

    // Channel 2 filled under stall, fifth push overflows, then drain.
    stall_2 = 1;
    for (int i = 0; i < 5; i++) begin
      push_2 = 1; push_data_2 = 32'hB0 + i;
      step();
    end
    push_2 = 0;
    step();
    chk("ch2_full_count", count_2, 4);
    chk("ch2_full_ready", push_ready_2, 0);
    chk("ch2_head_held", pipeline2_inputs, 32'hB0);
    chk("ch2_overflow", overflow[1], 1);
    stall_2 = 0;
    for (int i = 0; i < 4; i++) step();
    chk("ch2_drained", count_2, 0);

    // Steady push+pop at occupancy 2 across pointer wrap.
    stall_1 = 1;
    for (int i = 0; i < 2; i++) begin
      push_1 = 1; push_data_1 = 32'hC0 + i;
      step();
    end
    stall_1 = 0;
    for (int i = 0; i < 10; i++) begin
      push_data_1 = 32'hC2 + i;
      step();
      chk("ch1_steady_count", count_1, 2);
    end
    idle();
    step(); step();

    // Flush with a concurrent push while channel 2 keeps running.
    stall_1 = 1;
    for (int i = 0; i < 3; i++) begin
      push_1 = 1; push_data_1 = 32'hD0 + i;
      push_2 = 1; push_data_2 = 32'hE0 + i;
      step();
    end
    flush_1 = 1; push_1 = 1; push_data_1 = 32'hDF; push_2 = 1; push_data_2 = 32'hE3;
    #1;
    chk("flush_in_valid0", in_valid[0], 0);
    step();
    idle();
    chk("flush_count_1", count_1, 0);
    chk("flush_overflow", overflow, 2'b10);
    step(); step();

    // Random traffic on both channels.
    for (int i = 0; i < 400; i++) begin
      push_1 = ($urandom_range(0, 3) != 0); push_data_1 = $urandom;
      push_2 = ($urandom_range(0, 3) != 0); push_data_2 = $urandom;
      stall_1 = ($urandom_range(0, 9) < 4);
      stall_2 = ($urandom_range(0, 9) < 5);
      flush_1 = ($urandom_range(0, 29) == 0);
      flush_2 = ($urandom_range(0, 29) == 0);
      step();
    end

    // Async reset mid-stream with both channels non-empty.
    idle();
    stall_1 = 1; stall_2 = 1; push_1 = 1; push_2 = 1;
    push_data_1 = 32'h11; push_data_2 = 32'h22;
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_in_valid", in_valid, 2'b00);
    chk("arst_count_1", count_1, 0);
    chk("arst_count_2", count_2, 0);
    chk("arst_overflow", overflow, 2'b00);
    q1.delete(); q2.delete(); ov_m = 2'b00;
    idle();
    @(negedge clk);
    reset = 1'b1;
    push_1 = 1; push_data_1 = 32'h55;
    step();
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
